mem_slave: RTL and testbench
============================

MEM_SLAVE -- requirements
Module: mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; multiple of 8.
REQ-003 SHALL have parameter MEM_SIZE, default 4096, capacity in bytes; DEPTH = MEM_SIZE/(DATA_WIDTH/8) words.
REQ-004 SHALL have parameter WAIT_STATES, default 2, extra cycles inserted before each response (0 allowed).
REQ-005 SHALL have port clk input 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid input 1: request present.
REQ-008 SHALL have port req_ready output 1: block can accept a request.
REQ-009 SHALL have port req_wen input 1: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr input ADDR_WIDTH: byte address.
REQ-011 SHALL have port req_wdata input DATA_WIDTH: write data.
REQ-012 SHALL have port req_be input DATA_WIDTH/8: byte-lane write enables.
REQ-013 SHALL have port rsp_valid output 1: one-cycle response pulse.
REQ-014 SHALL have port rsp_rdata output DATA_WIDTH: read data, qualified by rsp_valid.
REQ-015 SHALL have port rsp_err output 1: out-of-range error, qualified by rsp_valid.

Function
REQ-016 SHALL implement FSM states INIT, IDLE, WAIT, RESP; one request outstanding at most.
REQ-017 SHALL assert req_ready only in IDLE; request accepted on edge where req_valid && req_ready, capturing wen, addr, wdata, be.
REQ-018 SHALL on acceptance go IDLE->WAIT with wait counter loaded to WAIT_STATES, or IDLE->RESP directly if WAIT_STATES = 0.
REQ-019 SHALL in WAIT decrement counter each cycle and go to RESP on the edge where counter reaches 0; total latency acceptance edge to rsp_valid high = WAIT_STATES+1 cycles.
REQ-020 SHALL hold rsp_valid high for exactly the single RESP cycle, then return to IDLE; no response backpressure.
REQ-021 SHALL form word index from req_addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low byte-offset bits ignored.
REQ-022 SHALL flag out-of-range when index >= DEPTH: rsp_err = 1, rsp_rdata = 0, memory unchanged.
REQ-023 SHALL commit in-range writes on the edge entering RESP, updating only lanes whose req_be bit is 1; be = 0 is a legal no-op with rsp_err = 0.
REQ-024 SHALL on in-range reads drive rsp_rdata with the stored word registered on the edge entering RESP; rsp_rdata = 0 for writes.
REQ-025 SHALL drive rsp_rdata = 0 and rsp_err = 0 whenever rsp_valid = 0.
REQ-026 SHALL ignore req_wen/addr/wdata/be changes while not in IDLE.

Reset
REQ-027 SHALL on rst = 1 immediately force req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
REQ-028 SHALL abort any request in flight on reset: no write committed, no response issued.
REQ-029 SHALL after rst deasserts enter INIT (macro defined) or IDLE (macro undefined).

Configuration
REQ-030 SHALL with MEM_SLAVE_ZERO_INIT_EN defined clear one word per cycle in INIT, index 0..DEPTH-1, req_ready = 0, then enter IDLE after DEPTH cycles.
REQ-031 SHALL with MEM_SLAVE_ZERO_INIT_EN undefined omit INIT and the sweep counter; memory contents undefined after reset.

Verification (defaults unless stated)
REQ-032 SHALL pass: write addr 0x0010 data 0xDEADBEEF be 0xF, then read 0x0010 -> each rsp_valid 3 cycles after acceptance; read rsp_rdata 0xDEADBEEF, rsp_err 0.
REQ-033 SHALL pass: write 0x11223344 be 0xF to 0x0020, then write 0xAABBCCDD be 0x5, read -> 0x11BB33DD.
REQ-034 SHALL pass: read addr 0x1000 (index 1024 >= DEPTH) -> rsp_err 1, rsp_rdata 0; prior data at 0x0000 unchanged.
REQ-035 SHALL pass: WAIT_STATES = 0, back-to-back req_valid -> rsp_valid one cycle after each acceptance, req_ready low in RESP, one acceptance per 2 cycles.
REQ-036 SHALL pass: assert rst during WAIT of write to 0x0040 -> no rsp_valid, read of 0x0040 after reset returns previous value (0 with macro defined).
REQ-037 SHALL pass: macro defined, MEM_SIZE = 64 -> req_ready low for 16 cycles after reset release, every word then reads 0.

Source files
------------

// File: rtl/mem_slave_if.sv
// Request/response bus between a requester and mem_slave.
// The master drives requests; the slave answers with a one-cycle response pulse.
interface mem_slave_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wen;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_slave.sv
// Word-organised memory slave with a fixed number of wait states per access.
// Define MEM_SLAVE_ZERO_INIT_EN to clear the whole memory after every reset.
module mem_slave #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_SIZE    = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_slave_if.slave   bus
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(BYTES);
    localparam int DEPTH  = MEM_SIZE / BYTES;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W  = ADDR_WIDTH - OFFS;
    localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
`ifdef MEM_SLAVE_ZERO_INIT_EN
        , ST_INIT
`endif
    } state_t;

`ifdef MEM_SLAVE_ZERO_INIT_EN
    localparam state_t ST_RST = ST_INIT;
    logic [MEM_AW-1:0] r_sweep;
`else
    localparam state_t ST_RST = ST_IDLE;
`endif

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_ready;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic                r_wen;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BYTES-1:0]    r_be;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                w_accept, w_enter_resp;
    logic                w_wen, w_in_range;
    logic [IDX_W-1:0]    w_idx;
    logic [MEM_AW-1:0]   w_mem_idx;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BYTES-1:0]    w_be;

    logic                w_wr_en;
    logic [MEM_AW-1:0]   w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [BYTES-1:0]    w_wr_be;

    // With zero wait states the response is formed on the acceptance edge, so
    // the live bus fields are used in IDLE and the captured copies elsewhere.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_wen   = bus.req_wen;
            w_idx   = bus.req_addr[ADDR_WIDTH-1:OFFS];
            w_wdata = bus.req_wdata;
            w_be    = bus.req_be;
        end else begin
            w_wen   = r_wen;
            w_idx   = r_idx;
            w_wdata = r_wdata;
            w_be    = r_be;
        end
        w_in_range = (32'(w_idx) < DEPTH);
        w_mem_idx  = w_idx[MEM_AW-1:0];
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
`ifdef MEM_SLAVE_ZERO_INIT_EN
            ST_INIT: if (r_sweep == MEM_AW'(DEPTH - 1)) w_state_nxt = ST_IDLE;
`endif
            ST_IDLE: begin
                if (bus.req_valid && r_ready) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_nxt  = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt  = ST_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wr_en   = w_enter_resp && w_wen && w_in_range;
        w_wr_idx  = w_mem_idx;
        w_wr_data = w_wdata;
        w_wr_be   = w_be;
`ifdef MEM_SLAVE_ZERO_INIT_EN
        if (r_state == ST_INIT) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_sweep;
            w_wr_data = '0;
            w_wr_be   = '1;
        end
`endif
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RST;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_wen       <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
`ifdef MEM_SLAVE_ZERO_INIT_EN
            r_sweep     <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= w_enter_resp;
            r_rsp_err   <= w_enter_resp && !w_in_range;
            r_rsp_rdata <= (w_enter_resp && !w_wen && w_in_range) ? r_mem[w_mem_idx] : '0;
            if (w_accept) begin
                r_wen   <= bus.req_wen;
                r_idx   <= bus.req_addr[ADDR_WIDTH-1:OFFS];
                r_wdata <= bus.req_wdata;
                r_be    <= bus.req_be;
            end
`ifdef MEM_SLAVE_ZERO_INIT_EN
            if (r_state == ST_INIT) r_sweep <= r_sweep + 1'b1;
`endif
        end
    end

    // NOTE: the storage array is deliberately not reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_wr_be[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_mem_slave.sv
// Directed plus randomized bench for mem_slave against a word/lane reference model.
// Honours MEM_SLAVE_ZERO_INIT_EN when the design is built with it.
module tb_mem_slave;
    localparam int WORDS = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();
    mem_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();

    mem_slave dut (.clk(clk), .rst(rst), .bus(bus));
    mem_slave #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

`ifdef MEM_SLAVE_ZERO_INIT_EN
    mem_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus64 ();
    mem_slave #(.MEM_SIZE(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: word contents plus a mask of bytes whose value is known.
    logic [31:0] m_data  [WORDS];
    logic [31:0] m_known [WORDS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    task automatic model_after_reset();
`ifdef MEM_SLAVE_ZERO_INIT_EN
        for (int i = 0; i < WORDS; i++) begin
            m_data[i]  = 32'h0;
            m_known[i] = 32'hFFFF_FFFF;
        end
`endif
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_timeout"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic txn(input logic wen, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int lat);
        @(negedge clk);
        wait_ready("txn");
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        @(negedge clk);
        // Scramble the request fields once accepted; the DUT must use its captured copy.
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'($urandom);
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        check("ready_low_in_resp", {31'b0, bus.req_ready}, 32'd0);
        @(negedge clk);
        check("rsp_flags_after_pulse", {30'b0, bus.rsp_valid, bus.rsp_err}, 32'd0);
        check("rsp_rdata_after_pulse", bus.rsp_rdata, 32'd0);
    endtask

    task automatic exec(input string tag, input logic wen, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, output logic [31:0] rd);
        int          idx;
        logic        exp_err;
        logic        err;
        int          lat;
        logic [31:0] mask;
        idx     = int'(addr) >> 2;
        exp_err = (idx >= WORDS);
        txn(wen, addr, wdata, be, rd, err, lat);
        check({tag, "_latency"}, lat, 32'd3);
        check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        if (!wen && !exp_err)
            check({tag, "_rdata"}, rd & m_known[idx], m_data[idx] & m_known[idx]);
        else
            check({tag, "_rdata_zero"}, rd, 32'd0);
        if (wen && !exp_err) begin
            mask         = lane_mask(be);
            m_data[idx]  = (m_data[idx] & ~mask) | (wdata & mask);
            m_known[idx] = m_known[idx] | mask;
        end
    endtask

    initial begin : watchdog
        #600_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] rd;
        logic [31:0] d0 [4];
        logic [31:0] exp_rd;
        int          n;
        int          idx;

        for (int i = 0; i < WORDS; i++) begin
            m_data[i]  = 32'h0;
            m_known[i] = 32'h0;
        end
        bus.req_valid  = 1'b0; bus.req_wen  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0; bus.req_be  = '0;
        bus0.req_valid = 1'b0; bus0.req_wen = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.req_be = '0;
`ifdef MEM_SLAVE_ZERO_INIT_EN
        bus64.req_valid = 1'b0; bus64.req_wen = 1'b0; bus64.req_addr = '0; bus64.req_wdata = '0; bus64.req_be = '0;
`endif

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'b0, bus.req_ready}, 32'd0);
        check("reset_rsp_flags", {30'b0, bus.rsp_valid, bus.rsp_err}, 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        rst = 1'b0;
        model_after_reset();

        // Basic write then read, three-cycle latency each
        exec("wr_10", 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, rd);
        exec("rd_10", 1'b0, 16'h0010, 32'h0, 4'h0, rd);
        check("rd_10_value", rd, 32'hDEAD_BEEF);

        // Byte-offset bits are ignored
        exec("rd_13", 1'b0, 16'h0013, 32'h0, 4'h0, rd);
        check("rd_13_value", rd, 32'hDEAD_BEEF);

        // Partial byte enables merge into the stored word
        exec("wr_20_full", 1'b1, 16'h0020, 32'h1122_3344, 4'hF, rd);
        exec("wr_20_be5", 1'b1, 16'h0020, 32'hAABB_CCDD, 4'h5, rd);
        exec("rd_20", 1'b0, 16'h0020, 32'h0, 4'h0, rd);
        check("rd_20_merge", rd, 32'h11BB_33DD);

        // be = 0 is a legal no-op
        exec("wr_10_be0", 1'b1, 16'h0010, 32'h0BAD_0BAD, 4'h0, rd);
        exec("rd_10_after_be0", 1'b0, 16'h0010, 32'h0, 4'h0, rd);
        check("rd_10_be0_value", rd, 32'hDEAD_BEEF);

        // Out-of-range accesses flag an error and leave memory alone
        exec("wr_00", 1'b1, 16'h0000, 32'h5A5A_A5A5, 4'hF, rd);
        exec("rd_1000_oor", 1'b0, 16'h1000, 32'h0, 4'h0, rd);
        exec("wr_1000_oor", 1'b1, 16'h1000, 32'hFFFF_FFFF, 4'hF, rd);
        exec("rd_00_after_oor", 1'b0, 16'h0000, 32'h0, 4'h0, rd);
        check("rd_00_unchanged", rd, 32'h5A5A_A5A5);

        // Randomized traffic over a small window plus occasional out-of-range hits
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) == 0) idx = 1024 + int'($urandom_range(0, 2000));
            else idx = 256 + int'($urandom_range(0, 7));
            exec("rand", 1'($urandom), 16'(idx * 4 + int'($urandom_range(0, 3))),
                 $urandom, 4'($urandom), rd);
        end

        // Reset raised while idle drops ready at once
        @(negedge clk);
        wait_ready("pre_async");
        rst = 1'b1;
        #1;
        check("async_reset_ready", {31'b0, bus.req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_after_reset();

        // Reset during the wait states of a write aborts it
        exec("wr_40_old", 1'b1, 16'h0040, 32'hCAFE_F00D, 4'hF, rd);
        @(negedge clk);
        wait_ready("abort");
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = 16'h0040;
        bus.req_wdata = 32'h1234_5678;
        bus.req_be    = 4'hF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("abort_no_early_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort_rsp_cleared", {30'b0, bus.rsp_valid, bus.rsp_err}, 32'd0);
        check("abort_rdata_cleared", bus.rsp_rdata, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_rsp_in_reset", {31'b0, bus.rsp_valid}, 32'd0);
        end
        rst = 1'b0;
        model_after_reset();
        exec("rd_40_after_abort", 1'b0, 16'h0040, 32'h0, 4'h0, rd);
`ifdef MEM_SLAVE_ZERO_INIT_EN
        exp_rd = 32'h0;
`else
        exp_rd = 32'hCAFE_F00D;
`endif
        check("rd_40_abort_value", rd, exp_rd);

        // Zero-wait-state instance with req_valid held high: four writes then four reads
        for (int i = 0; i < 4; i++) d0[i] = $urandom;
        @(negedge clk);
        n = 0;
        while (bus0.req_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ws0_ready_timeout", 32'(n < 3000), 32'd1);
        for (int c = 0; c < 16; c++) begin
            int k;
            k = c / 2;
            bus0.req_valid = 1'b1;
            bus0.req_wen   = (k < 4);
            bus0.req_addr  = 16'(((k % 4) + 32) * 4);
            bus0.req_wdata = d0[k % 4];
            bus0.req_be    = 4'hF;
            check("ws0_ready_pattern", {31'b0, bus0.req_ready}, 32'((c % 2) == 0));
            check("ws0_rsp_pattern", {31'b0, bus0.rsp_valid}, 32'((c % 2) == 1));
            if ((c % 2) == 1) begin
                check("ws0_rdata", bus0.rsp_rdata, (k < 4) ? 32'h0 : d0[k % 4]);
                check("ws0_err", {31'b0, bus0.rsp_err}, 32'd0);
            end
            @(negedge clk);
        end
        bus0.req_valid = 1'b0;

`ifdef MEM_SLAVE_ZERO_INIT_EN
        // Small instance: sixteen-cycle clear, then every word reads zero
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (bus64.req_ready === 1'b1) break;
        end
        check("init_ready_cycles", n, 32'd16);
        for (int w = 0; w < 16; w++) begin
            int lat;
            @(negedge clk);
            bus64.req_valid = 1'b1;
            bus64.req_wen   = 1'b0;
            bus64.req_addr  = 16'(w * 4);
            @(negedge clk);
            bus64.req_valid = 1'b0;
            lat = 1;
            while (bus64.rsp_valid !== 1'b1 && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            check("init_word_latency", lat, 32'd3);
            check("init_word_zero", bus64.rsp_rdata, 32'd0);
            check("init_word_err", {31'b0, bus64.rsp_err}, 32'd0);
            @(negedge clk);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
